// File: rtl/fetch_unit.sv
// fetch_unit: PC generator issuing single-outstanding imem fetches into a prefetch queue feeding decode.
module fetch_unit #(
  parameter int XLEN = 32,
  parameter int DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int PC_INC = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       redirect_en,
  input  logic [XLEN-1:0]            redirect_pc,
  output logic                       imem_req,
  output logic [XLEN-1:0]            imem_addr,
  input  logic                       imem_gnt,
  input  logic                       imem_rvalid,
  input  logic [31:0]                imem_rdata,
  output logic                       id_valid,
  output logic [XLEN-1:0]            id_pc,
  output logic [31:0]                id_instr,
  input  logic                       id_ready,
  output logic [$clog2(DEPTH):0]     fq_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [XLEN-1:0] pc_fetch, req_pc;
  logic outstanding, discard, full, grant, push, pop;
  logic [AW-1:0] rptr, wptr;
  logic [XLEN-1:0] pc_q [DEPTH];
  logic [31:0] instr_q [DEPTH];
  always_comb begin
    full = fq_count == CW'(DEPTH);
    imem_req = !rst && !redirect_en && !outstanding && !full;
    imem_addr = pc_fetch;
    grant = imem_req && imem_gnt;
    push = !rst && !redirect_en && imem_rvalid && outstanding && !discard;
    id_valid = fq_count != '0;
    pop = !redirect_en && id_valid && id_ready;
    id_pc = id_valid ? pc_q[rptr] : '0;
    id_instr = id_valid ? instr_q[rptr] : 32'h0000_0013;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_fetch <= RESET_PC;
      req_pc <= RESET_PC;
      outstanding <= 1'b0;
      discard <= 1'b0;
      rptr <= '0;
      wptr <= '0;
      fq_count <= '0;
    end else if (redirect_en) begin
      pc_fetch <= redirect_pc & ~XLEN'(3);
      rptr <= '0;
      wptr <= '0;
      fq_count <= '0;
      // a response already on the bus dies here; otherwise the stale one must be swallowed later
      if (imem_rvalid) begin
        outstanding <= 1'b0;
        discard <= 1'b0;
      end else if (outstanding) discard <= 1'b1;
    end else begin
      if (grant) begin
        outstanding <= 1'b1;
        req_pc <= pc_fetch;
        pc_fetch <= pc_fetch + XLEN'(PC_INC);
      end else if (imem_rvalid) begin
        outstanding <= 1'b0;
        discard <= 1'b0;
      end
      if (push) wptr <= wptr + AW'(1);
      if (pop) rptr <= rptr + AW'(1);
      fq_count <= fq_count + CW'(push) - CW'(pop);
    end
  end
  always_ff @(posedge clk)
    if (push) begin
      pc_q[wptr] <= req_pc;
      instr_q[wptr] <= imem_rdata;
    end
  // the credit rule (single outstanding, no issue when full) must keep pushes out of a full queue
  assert property (@(posedge clk) disable iff (rst) !(push && full));
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: random memory/decode/redirect stimulus with a scoreboard of expected sequential fetch streams.
module tb_fetch_unit;
  localparam int DEPTH = 4;
  localparam logic [31:0] RESET_PC = 32'h0;
  logic clk = 0, rst = 1, redirect_en = 0, imem_gnt = 0, imem_rvalid = 0, id_ready = 0;
  logic [31:0] redirect_pc = '0, imem_rdata = '0;
  logic imem_req, id_valid;
  logic [31:0] imem_addr, id_pc, id_instr;
  logic [2:0] fq_count;

  fetch_unit #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(RESET_PC), .PC_INC(4)) dut (
    .clk(clk), .rst(rst), .redirect_en(redirect_en), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .id_valid(id_valid), .id_pc(id_pc), .id_instr(id_instr), .id_ready(id_ready),
    .fq_count(fq_count));

  always #5 clk = ~clk;

  int checks = 0, errors = 0, handshakes = 0;
  logic [63:0] exp_q [$];
  logic [31:0] exp_next, exp_addr;
  int epoch = 0, occ = 0;
  bit rv_live = 0;
  int p_gnt = 100, p_ready = 100, lat_lo = 1, lat_hi = 1, gnt_block = 0;
  bit spurious = 0;
  bit pend = 0;
  int cnt = 0, pend_epoch = 0;
  logic [31:0] pend_addr = '0;
  bit last_g = 0;
  logic [31:0] last_ga = '0;
  bit prev_stall = 0;
  logic [31:0] prev_addr = '0;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1234_5678;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // a reset or redirect starts a fresh sequential stream from pc
  task automatic restart(input logic [31:0] pc);
    epoch++;
    exp_q.delete();
    exp_next = pc;
    exp_addr = pc;
  endtask

  task automatic cycle(input bit do_rst = 0, input bit do_redir = 0, input logic [31:0] tgt = '0);
    @(negedge clk);
    last_g = imem_req && imem_gnt;
    last_ga = imem_addr;
    @(posedge clk);
    #1;
    if (imem_rvalid) pend = 0;
    if (last_g) begin
      pend = 1;
      pend_addr = last_ga;
      pend_epoch = epoch;
      cnt = $urandom_range(lat_hi, lat_lo) - 1;
    end else if (pend && cnt > 0) cnt--;
    rst = do_rst;
    redirect_en = do_redir && !do_rst;
    redirect_pc = tgt;
    if (do_rst) restart(RESET_PC);
    else if (do_redir) restart({tgt[31:2], 2'b00});
    imem_rvalid = pend ? cnt == 0 : (spurious && $urandom_range(7) == 0);
    rv_live = imem_rvalid && pend && pend_epoch == epoch;
    imem_rdata = (imem_rvalid && pend) ? instr_of(pend_addr) : $urandom;
    imem_gnt = gnt_block > 0 ? 1'b0 : $urandom_range(99) < p_gnt;
    if (gnt_block > 0) gnt_block--;
    id_ready = $urandom_range(99) < p_ready;
    while (exp_q.size() < 16) begin
      exp_q.push_back({exp_next, instr_of(exp_next)});
      exp_next += 32'd4;
    end
  endtask

  task automatic wait_grant(input logic [31:0] addr);
    bit seen = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      cycle();
      seen = last_g && (addr == 32'hFFFF_FFFF || last_ga == addr);
    end
    check("wait_grant", seen, 1);
  endtask

  always @(negedge clk) begin
    logic [63:0] e;
    if (!rst) begin
      check("fq_count", fq_count, occ);
      check("id_valid", id_valid, occ != 0);
      if (occ == 0) begin
        check("empty_pc", id_pc, 0);
        check("empty_instr", id_instr, 32'h13);
      end
      if (occ == DEPTH) check("req_when_full", imem_req, 0);
      if (prev_stall && !redirect_en) begin
        check("held_req", imem_req, 1);
        check("held_addr", imem_addr, prev_addr);
      end
      if (redirect_en) check("req_in_redirect", imem_req, 0);
      if (imem_req && imem_gnt) begin
        check("grant_addr", imem_addr, exp_addr);
        exp_addr += 32'd4;
      end
      if (!redirect_en && occ != 0 && id_ready) begin
        handshakes++;
        if (exp_q.size() == 0) check("scoreboard_empty", 1, 0);
        else begin
          e = exp_q.pop_front();
          check("id_pc", id_pc, e[63:32]);
          check("id_instr", id_instr, e[31:0]);
        end
      end
    end else check("req_in_rst", imem_req, 0);
    prev_stall = !rst && !redirect_en && imem_req && !imem_gnt;
    prev_addr = imem_addr;
    occ = (rst || redirect_en) ? 0 : occ + int'(rv_live) - int'(occ != 0 && id_ready);
  end

  initial begin
    restart(RESET_PC);
    p_ready = 0;
    repeat (3) cycle(1);
    repeat (20) cycle();
    check("saturated_count", fq_count, DEPTH);
    check("saturated_head", id_pc, 32'h0);
    p_ready = 100;
    repeat (30) cycle();
    // stale response must be discarded after a redirect to an unaligned target
    cycle(1);
    lat_lo = 3; lat_hi = 3;
    wait_grant(32'h8);
    cycle(0, 1, 32'h0000_0102);
    check("count_after_redirect", fq_count, 0);
    repeat (30) cycle();
    // grant withheld: request and address must hold
    lat_lo = 1; lat_hi = 1;
    gnt_block = 6;
    repeat (12) cycle();
    // reset with a response still in flight
    lat_lo = 4; lat_hi = 4;
    wait_grant(32'hFFFF_FFFF);
    gnt_block = 7;
    cycle(1);
    repeat (20) cycle();
    // redirect near the top of the address space to exercise PC wrap
    lat_lo = 1; lat_hi = 2;
    cycle(0, 1, 32'hFFFF_FFF3);
    repeat (30) cycle();
    p_gnt = 60; p_ready = 70; lat_lo = 1; lat_hi = 4; spurious = 1;
    for (int i = 0; i < 3000; i++) begin
      int r;
      logic [31:0] t;
      r = $urandom_range(999);
      t = $urandom_range(3) == 0 ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom;
      cycle(r < 5, r >= 5 && r < 35, t);
    end
    repeat (10) cycle();
    check("progress", handshakes > 200, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Parametrised instruction-fetch stage for the RV32IM pipeline. It replaces the fixed PC + adder + mux + IF/ID register chain with a PC generator that drives a variable-latency instruction-memory request/response interface. Fetched {pc, instr} pairs are buffered in a DEPTH-entry prefetch queue. The queue feeds decode through a valid/ready handshake, and an EX-stage redirect flushes the queue and any in-flight fetch.

Parameters:
XLEN, 32, PC and address width
DEPTH, 4, prefetch queue entries; power of 2, >= 2
RESET_PC, 32'h0000_0000, PC loaded on reset
PC_INC, 4, sequential PC increment

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
redirect_en  in  1  taken branch/jump from EX
redirect_pc  in  XLEN  redirect target
imem_req  out  1  fetch request
imem_addr  out  XLEN  fetch address
imem_gnt  in  1  request accepted this cycle
imem_rvalid  in  1  response data valid
imem_rdata  in  32  fetched instruction
id_valid  out  1  queue head valid to decode
id_pc  out  XLEN  PC of head entry
id_instr  out  32  instruction of head entry
id_ready  in  1  decode accepts head (stall = !id_ready)
fq_count  out  $clog2(DEPTH)+1  current queue occupancy

Behaviour:
- Reset (sync, highest priority):
  - pc_fetch = RESET_PC; queue empty; fq_count = 0; outstanding = 0; discard = 0.
  - id_valid = 0; imem_req = 0.
- Empty queue: id_pc = 0, id_instr = 32'h0000_0013 (NOP).
- Non-empty queue: id_pc and id_instr show the head entry, combinationally.
- Request issue:
  - imem_req = !rst & !redirect_en & !outstanding & (fq_count < DEPTH).
  - imem_addr = pc_fetch. It is held stable while imem_req=1 and imem_gnt=0.
  - At most one request is outstanding.
- On imem_req & imem_gnt:
  - outstanding <= 1; req_pc <= pc_fetch.
  - pc_fetch <= pc_fetch + PC_INC, modulo 2^XLEN (0xFFFF_FFFC wraps to 0).
- Response handling:
  - imem_rvalid with outstanding=1 and discard=0: push {req_pc, imem_rdata}; outstanding <= 0.
  - imem_rvalid with discard=1: drop the data; outstanding <= 0; discard <= 0.
  - imem_rvalid with outstanding=0: ignored.
  - Earliest response is the cycle after the grant.
- Overflow: the credit rule (no issue when full, single outstanding) guarantees a push never occurs when full. Implementation must assert on it in simulation.
- Dequeue: id_valid = (fq_count != 0). Pop when id_valid & id_ready.
- Simultaneous push and pop: fq_count unchanged. The entry enters the tail while the head advances.
- Push into empty queue: visible on id_* in the cycle after imem_rvalid (1-cycle queue latency).
- Read pointer and write pointer wrap modulo DEPTH.
- Redirect (redirect_en=1), effective at the next edge, with priority over push, pop and grant:
  - Queue cleared; fq_count <= 0.
  - pc_fetch <= {redirect_pc[XLEN-1:2], 2'b00}.
  - If outstanding=1 and no imem_rvalid this cycle: discard <= 1.
  - If imem_rvalid arrives in the same cycle: the data is dropped and outstanding <= 0.
  - No request is issued in the redirect cycle.
  - A pop in the same cycle has no further effect; killing an ID instruction is the hazard unit's job.
- Back-to-back redirects: the last one wins; discard stays set until the stale response returns.
- Reset mid-fetch: outstanding and discard cleared. Any later imem_rvalid with outstanding=0 is ignored.
- Steady state with 1-cycle memory and id_ready=1: one instruction every 2 cycles (single-outstanding limit; documented, not a bug).

Test Plan:
- Reset, then memory with 1-cycle latency and always-grant, id_ready=1 -> imem_addr sequence 0x0, 0x4, 0x8; id_pc sequence 0x0, 0x4, 0x8 with matching id_instr; id_valid=0 in the first 2 cycles after reset.
- Hold id_ready=0 with DEPTH=4 -> fq_count saturates at 4; imem_req=0 while full. Raise id_ready -> entries drain in order with PCs 0x0..0xC; fetching resumes at 0x10.
- Redirect to 0x0000_0102 while a request to 0x8 is outstanding, response 3 cycles later -> that response is dropped; next imem_addr = 0x100; first id_pc after redirect = 0x100; fq_count = 0 the cycle after redirect.
- imem_gnt held low 5 cycles -> imem_req and imem_addr=0x4 stable throughout; pc_fetch advances only on the grant cycle.
- Simultaneous push and pop with fq_count=2 -> fq_count stays 2; head advances; order is preserved across pointer wrap (fetch of 12+ instructions).
- Assert rst mid-fetch with a pending response -> after reset imem_addr = RESET_PC; the late imem_rvalid is ignored; id_valid stays 0 until the new fetch returns.
